// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, NOP encoding, default widths and PC step.
package cpu_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_INST_W = 32;
   localparam int unsigned PC_INC     = 4;
   localparam logic [31:0] NOP_INST   = 32'h0;

   typedef enum logic [1:0] {
      FetchIdle,
      FetchReq,
      FetchHold,
      FetchDiscard
   } fetch_state_e;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid buffer parking a fetched instruction while the ID stage stalls.
module if_hold_buf
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned INST_W = DEF_INST_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic              drain_i,
   input  logic [INST_W-1:0] inst_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              valid_o
);

   logic [INST_W-1:0] inst_q;
   logic [ADDR_W-1:0] pc_q;
   logic              valid_q;

   // Clear (flush) wins over load; drain only consumes the entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst_q  <= INST_W'(NOP_INST);
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (clear_i) begin
         inst_q  <= INST_W'(NOP_INST);
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         inst_q  <= inst_i;
         pc_q    <= pc_i;
         valid_q <= 1'b1;
      end else if (drain_i) begin
         valid_q <= 1'b0;
      end
   end

   assign inst_o  = inst_q;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: drives the PC register, fetches from imem and loads IF/ID,
// absorbing memory wait states, ID stalls and branch/jump redirects.
module if_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned INST_W = DEF_INST_W,
   parameter int unsigned PC_INC = cpu_pkg::PC_INC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] i_pc,
   output logic [ADDR_W-1:0] o_pc_next,
   output logic              o_pc_keep,
   output logic              o_imem_req,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic              i_imem_ack,
   input  logic [INST_W-1:0] i_imem_rdata,
   input  logic              i_stall,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic              o_inst_valid,
   output logic [INST_W-1:0] o_inst,
   output logic [ADDR_W-1:0] o_inst_pc
);

   fetch_state_e      state_q, state_d;
   logic              inst_valid_q, inst_valid_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
   logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;

   logic              buf_load, buf_clear, buf_drain, buf_valid;
   logic [INST_W-1:0] buf_inst;
   logic [ADDR_W-1:0] buf_pc;

   logic              imem_req, ack;
   logic [ADDR_W-1:0] pc_inc;

   assign imem_req    = (state_q == FetchReq) || (state_q == FetchDiscard);
   assign ack         = i_imem_ack & imem_req;
   assign pc_inc      = i_pc + ADDR_W'(PC_INC);
   assign o_imem_req  = imem_req;
   // Discard keeps presenting the abandoned address until its ack retires it.
   assign o_imem_addr = (state_q == FetchDiscard) ? disc_addr_q : i_pc;

   if_hold_buf #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_hold_buf (
      .clk     (clk),
      .reset   (reset),
      .load_i  (buf_load),
      .clear_i (buf_clear),
      .drain_i (buf_drain),
      .inst_i  (i_imem_rdata),
      .pc_i    (i_pc),
      .inst_o  (buf_inst),
      .pc_o    (buf_pc),
      .valid_o (buf_valid)
   );

   always_comb begin
      state_d      = state_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      disc_addr_d  = disc_addr_q;
      o_pc_keep    = 1'b1;
      o_pc_next    = i_pc;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;
      buf_drain    = 1'b0;

      if (i_redirect) begin
         o_pc_keep    = 1'b0;
         o_pc_next    = i_redirect_pc;
         inst_valid_d = 1'b0;
         buf_clear    = 1'b1;
         if (state_q == FetchReq && !ack) begin
            state_d     = FetchDiscard;
            disc_addr_d = i_pc;
         end else if (state_q == FetchDiscard && !ack) begin
            state_d = FetchDiscard;
         end else begin
            state_d = FetchReq;
         end
      end else begin
         unique case (state_q)
            FetchIdle: state_d = FetchReq;
            FetchReq: begin
               if (ack && !i_stall) begin
                  inst_d       = i_imem_rdata;
                  inst_pc_d    = i_pc;
                  inst_valid_d = 1'b1;
                  o_pc_keep    = 1'b0;
                  o_pc_next    = pc_inc;
               end else if (ack) begin
                  buf_load = 1'b1;
                  state_d  = FetchHold;
               end else if (!i_stall) begin
                  inst_valid_d = 1'b0;
               end
            end
            FetchHold: begin
               if (!i_stall) begin
                  inst_d       = buf_inst;
                  inst_pc_d    = buf_pc;
                  inst_valid_d = buf_valid;
                  buf_drain    = 1'b1;
                  o_pc_keep    = 1'b0;
                  o_pc_next    = pc_inc;
                  state_d      = FetchReq;
               end
            end
            FetchDiscard: begin
               if (ack) begin
                  state_d = FetchReq;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= FetchIdle;
         inst_valid_q <= 1'b0;
         inst_q       <= INST_W'(NOP_INST);
         inst_pc_q    <= '0;
         disc_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         disc_addr_q  <= disc_addr_d;
      end
   end

   assign o_inst_valid = inst_valid_q;
   assign o_inst       = inst_q;
   assign o_inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: emulates the PC register and checks every cycle against a
// transaction-level fetch model, plus hand-computed pins for each directed scenario.
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_reg;
   logic [31:0] o_pc_next, o_imem_addr, o_inst, o_inst_pc;
   logic        o_pc_keep, o_imem_req, o_inst_valid;
   logic        ack, stall, redir;
   logic [31:0] rdata, redir_pc;

   int checks = 0;
   int errors = 0;

   // Model: where the fetch engine is and what IF/ID must show.
   bit          m_idle, m_held, m_drop;
   logic [31:0] m_drop_addr, m_held_inst, m_held_pc;
   bit          e_valid;
   logic [31:0] e_inst, e_pc;

   always #5 clk = ~clk;

   if_fetch_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .i_pc          (pc_reg),
      .o_pc_next     (o_pc_next),
      .o_pc_keep     (o_pc_keep),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ack    (ack),
      .i_imem_rdata  (rdata),
      .i_stall       (stall),
      .i_redirect    (redir),
      .i_redirect_pc (redir_pc),
      .o_inst_valid  (o_inst_valid),
      .o_inst        (o_inst),
      .o_inst_pc     (o_inst_pc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit a, input logic [31:0] d, input bit s, input bit r,
                        input logic [31:0] rp);
      ack = a; rdata = d; stall = s; redir = r; redir_pc = rp;
   endtask

   // One clock: compare at negedge, advance model just after posedge.
   task automatic tick();
      bit          busy, e_req, e_keep, a_eff;
      logic [31:0] e_addr, e_next;
      @(negedge clk);
      if (reset) begin
         m_idle = 1; m_held = 0; m_drop = 0;
         e_valid = 0; e_inst = 0; e_pc = 0; pc_reg = 0;
      end
      busy   = !m_idle && !m_held && !m_drop;
      e_req  = busy || m_drop;
      e_addr = m_drop ? m_drop_addr : pc_reg;
      a_eff  = ack && e_req;
      e_keep = 1; e_next = pc_reg;
      if (redir) begin
         e_keep = 0; e_next = redir_pc;
      end else if ((m_held && !stall) || (busy && a_eff && !stall)) begin
         e_keep = 0; e_next = pc_reg + 32'd4;
      end
      chk("req", {31'b0, o_imem_req}, {31'b0, e_req});
      if (e_req) chk("addr", o_imem_addr, e_addr);
      chk("keep", {31'b0, o_pc_keep}, {31'b0, e_keep});
      chk("pc_next", o_pc_next, e_next);
      chk("valid", {31'b0, o_inst_valid}, {31'b0, e_valid});
      if (e_valid) begin
         chk("inst", o_inst, e_inst);
         chk("inst_pc", o_inst_pc, e_pc);
      end
      @(posedge clk);
      #1;
      if (reset) return;
      if (redir) begin
         e_valid = 0;
         if (busy && !a_eff) begin
            m_drop = 1; m_drop_addr = pc_reg;
         end else if (!(m_drop && !a_eff)) begin
            m_drop = 0;
         end
         m_held = 0; m_idle = 0;
      end else if (m_idle) begin
         m_idle = 0;
      end else if (m_held) begin
         if (!stall) begin
            e_valid = 1; e_inst = m_held_inst; e_pc = m_held_pc; m_held = 0;
         end
      end else if (m_drop) begin
         if (a_eff) m_drop = 0;
      end else if (a_eff && !stall) begin
         e_valid = 1; e_inst = rdata; e_pc = pc_reg;
      end else if (a_eff) begin
         m_held = 1; m_held_inst = rdata; m_held_pc = pc_reg;
      end else if (!stall) begin
         e_valid = 0;
      end
      if (!e_keep) pc_reg = e_next;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      reset = 1; pc_reg = 0;
      drive(0, 0, 0, 0, 0);
      tick(); tick();
      reset = 0;
      #1 chk("idle_no_req", {31'b0, o_imem_req}, 32'd0);
      tick();
      #1 chk("first_req", {31'b0, o_imem_req}, 32'd1);
      chk("first_addr", o_imem_addr, 32'h0);
      tick();
      // Reset asserted mid-request.
      reset = 1;
      #1 chk("rst_req", {31'b0, o_imem_req}, 32'd0);
      chk("rst_valid", {31'b0, o_inst_valid}, 32'd0);
      chk("rst_inst", o_inst, 32'h0);
      tick();
      reset = 0;
      tick();
      #1 chk("post_rst_addr", o_imem_addr, 32'h0);

      // Zero-wait stream, rdata = address.
      for (int i = 0; i < 4; i++) begin
         drive(1, pc_reg, 0, 0, 0);
         tick();
         chk("stream_pc", o_inst_pc, 32'(i * 4));
         chk("stream_inst", o_inst, 32'(i * 4));
      end

      // Three wait states at 0x10.
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0);
         #1 chk("wait_addr", o_imem_addr, 32'h10);
         chk("wait_keep", {31'b0, o_pc_keep}, 32'd1);
         tick();
      end
      drive(1, 32'hA0, 0, 0, 0);
      tick();
      chk("wait_done_pc", o_inst_pc, 32'h10);
      chk("wait_done_valid", {31'b0, o_inst_valid}, 32'd1);

      // Stall as 0x20 is acked.
      for (int i = 0; i < 3; i++) begin
         drive(1, pc_reg, 0, 0, 0);
         tick();
      end
      drive(1, 32'hB20, 1, 0, 0);
      tick();
      drive(0, 0, 1, 0, 0);
      #1 chk("hold_no_req", {31'b0, o_imem_req}, 32'd0);
      chk("hold_keep", {31'b0, o_pc_keep}, 32'd1);
      tick();
      drive(0, 0, 0, 0, 0);
      #1 chk("drain_next", o_pc_next, 32'h24);
      tick();
      chk("drain_pc", o_inst_pc, 32'h20);
      chk("drain_inst", o_inst, 32'hB20);
      #1 chk("after_hold_addr", o_imem_addr, 32'h24);

      // Stream up to 0x40, then redirect while its request is pending.
      guard = 0;
      while (pc_reg != 32'h40 && guard < 20) begin
         drive(1, pc_reg, 0, 0, 0);
         tick();
         guard++;
      end
      if (guard >= 20) chk("reach_40", pc_reg, 32'h40);
      drive(0, 0, 0, 1, 32'h100);
      tick();
      drive(0, 0, 0, 0, 0);
      #1 chk("disc_addr", o_imem_addr, 32'h40);
      tick();
      drive(1, 32'hDEAD, 0, 0, 0);
      tick();
      chk("disc_dropped", {31'b0, o_inst_valid}, 32'd0);
      drive(1, 32'h100, 0, 0, 0);
      #1 chk("target_addr", o_imem_addr, 32'h100);
      tick();
      chk("target_pc", o_inst_pc, 32'h100);

      // Redirect + ack + stall together, then wrap past the top of memory.
      drive(1, 32'h104, 1, 1, 32'hFFFF_FFF8);
      #1 chk("rsa_next", o_pc_next, 32'hFFFF_FFF8);
      tick();
      chk("rsa_flush", {31'b0, o_inst_valid}, 32'd0);
      drive(1, pc_reg, 0, 0, 0);
      tick();
      drive(1, pc_reg, 0, 0, 0);
      #1 chk("wrap_next", o_pc_next, 32'h0);
      tick();
      chk("wrap_pc", o_inst_pc, 32'hFFFF_FFFC);

      // Redirect out of HOLD drops the parked instruction.
      drive(1, 32'h77, 1, 0, 0);
      tick();
      drive(0, 0, 1, 1, 32'h200);
      tick();
      drive(1, 32'h200, 0, 0, 0);
      tick();
      chk("hold_redir_pc", o_inst_pc, 32'h200);

      // Back-to-back redirects while a discard is outstanding.
      drive(0, 0, 0, 1, 32'h300);
      tick();
      drive(0, 0, 0, 1, 32'h400);
      tick();
      drive(0, 0, 0, 0, 0);
      #1 chk("disc_kept_addr", o_imem_addr, 32'h204);
      tick();
      drive(1, 32'hBAD, 0, 0, 0);
      tick();
      drive(1, 32'h400, 0, 0, 0);
      tick();
      chk("double_redir_pc", o_inst_pc, 32'h400);

      drive(0, 0, 0, 0, 0);
      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
